// File: rtl/ariane_axi_id_remap.sv
// ariane_axi_id_remap
//   Maps AXI IDs from a wide slave port (crossbar side) onto a narrow master
//   port (memory/LLC side). The write (AW/B) and read (AR/R) directions each
//   own a table of 2**AxiMstPortIdWidth entries {in_id, cnt}. The downstream
//   ID is the table index. Responses carry the index back, and it is
//   translated to the stored in_id. W passes straight through.
//
//   Optional feature macro: ARIANE_AXI_ID_REMAP_ATOP_EN
//     defined   : an AW with atop[5]=1 allocates one index in both tables
//     undefined : atop is forced to 0 downstream (plain writes only)
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   slv_req_i   upstream request   (wide IDs)
//   slv_resp_o  upstream response  (wide IDs)
//   mst_req_o   downstream request (remapped IDs)
//   mst_resp_i  downstream response (remapped IDs)

package ariane_axi_id_remap_pkg;
    localparam int unsigned SlvIdW = 5;
    localparam int unsigned MstIdW = 4;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic              user;
    } slv_aw_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic              user;
    } mst_aw_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic              user;
    } slv_ar_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [63:0]       addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic              user;
    } mst_ar_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
        logic        user;
    } w_chan_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [1:0]        resp;
        logic              user;
    } slv_b_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [1:0]        resp;
        logic              user;
    } mst_b_t;

    typedef struct packed {
        logic [SlvIdW-1:0] id;
        logic [63:0]       data;
        logic [1:0]        resp;
        logic              last;
        logic              user;
    } slv_r_t;

    typedef struct packed {
        logic [MstIdW-1:0] id;
        logic [63:0]       data;
        logic [1:0]        resp;
        logic              last;
        logic              user;
    } mst_r_t;

    typedef struct packed {
        slv_aw_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        slv_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        slv_b_t b;
        logic   r_valid;
        slv_r_t r;
    } slv_resp_t;

    typedef struct packed {
        mst_aw_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        mst_ar_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        mst_b_t b;
        logic   r_valid;
        mst_r_t r;
    } mst_resp_t;
endpackage

module ariane_axi_id_remap #(
    parameter int unsigned AxiSlvPortIdWidth = 5,
    parameter int unsigned AxiMstPortIdWidth = 4,
    parameter int unsigned MaxTxnsPerId      = 8,
    parameter type slv_req_t  = ariane_axi_id_remap_pkg::slv_req_t,
    parameter type slv_resp_t = ariane_axi_id_remap_pkg::slv_resp_t,
    parameter type mst_req_t  = ariane_axi_id_remap_pkg::mst_req_t,
    parameter type mst_resp_t = ariane_axi_id_remap_pkg::mst_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i
);
    localparam int NumIds = 2**AxiMstPortIdWidth;
    localparam int CntW   = $clog2(MaxTxnsPerId+1);

    typedef logic [AxiSlvPortIdWidth-1:0] sid_t;
    typedef logic [AxiMstPortIdWidth-1:0] mid_t;
    typedef logic [CntW-1:0]              cnt_t;

    localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

    sid_t w_in_id [NumIds];
    cnt_t w_cnt   [NumIds];
    sid_t r_in_id [NumIds];
    cnt_t r_cnt   [NumIds];

    logic aw_hold_q, ar_hold_q;
    mid_t aw_hold_idx, ar_hold_idx;

    logic aw_hit, aw_free, aw_ok, atop_rd;
    mid_t aw_hit_idx, aw_free_idx, aw_idx, aw_sel_idx;
    logic ar_hit, ar_free, ar_ok, ar_conflict;
    mid_t ar_hit_idx, ar_free_idx, ar_idx, ar_sel_idx;
    logic mst_aw_valid, mst_ar_valid, aw_stall, ar_stall;
    logic aw_hs, ar_hs, b_hs, r_hs;
    logic wok, rok;

    logic [NumIds-1:0] w_inc, w_dec, r_inc_ar, r_inc_aw, r_dec;

    // Write-table lookup. Iterating downwards leaves the lowest match.
    always_comb begin
        aw_hit      = 1'b0;
        aw_hit_idx  = '0;
        aw_free     = 1'b0;
        aw_free_idx = '0;
        atop_rd     = 1'b0;
        wok         = 1'b0;
        rok         = 1'b0;
        for (int i = NumIds-1; i >= 0; i--) begin
            if (w_cnt[i] != '0 && w_in_id[i] == slv_req_i.aw.id) begin
                aw_hit     = 1'b1;
                aw_hit_idx = mid_t'(i);
            end
            if (w_cnt[i] == '0) begin
                aw_free     = 1'b1;
                aw_free_idx = mid_t'(i);
            end
        end
        aw_ok  = aw_hit ? (w_cnt[aw_hit_idx] < CntMax) : aw_free;
        aw_idx = aw_hit ? aw_hit_idx : aw_free_idx;
`ifdef ARIANE_AXI_ID_REMAP_ATOP_EN
        // ATOPs returning an R burst need one index usable in both tables.
        // A held AR already owns its read index, so keep off it.
        if (slv_req_i.aw.atop[5]) begin
            atop_rd = 1'b1;
            aw_ok   = 1'b0;
            aw_idx  = '0;
            for (int i = NumIds-1; i >= 0; i--) begin
                wok = aw_hit ? (mid_t'(i) == aw_hit_idx && w_cnt[i] < CntMax)
                             : (w_cnt[i] == '0);
                rok = (r_cnt[i] == '0 ||
                       (r_in_id[i] == slv_req_i.aw.id && r_cnt[i] < CntMax)) &&
                      !(ar_hold_q && ar_hold_idx == mid_t'(i));
                if (wok && rok) begin
                    aw_ok  = 1'b1;
                    aw_idx = mid_t'(i);
                end
            end
        end
`endif
    end

    // Read-table lookup.
    always_comb begin
        ar_hit      = 1'b0;
        ar_hit_idx  = '0;
        ar_free     = 1'b0;
        ar_free_idx = '0;
        for (int i = NumIds-1; i >= 0; i--) begin
            if (r_cnt[i] != '0 && r_in_id[i] == slv_req_i.ar.id) begin
                ar_hit     = 1'b1;
                ar_hit_idx = mid_t'(i);
            end
            if (r_cnt[i] == '0) begin
                ar_free     = 1'b1;
                ar_free_idx = mid_t'(i);
            end
        end
        ar_ok  = ar_hit ? (r_cnt[ar_hit_idx] < CntMax) : ar_free;
        ar_idx = ar_hit ? ar_hit_idx : ar_free_idx;
    end

    // Once valid is up downstream, the registered index wins over any new lookup.
    assign aw_sel_idx   = aw_hold_q ? aw_hold_idx : aw_idx;
    assign ar_sel_idx   = ar_hold_q ? ar_hold_idx : ar_idx;
    assign aw_stall     = !aw_hold_q && !aw_ok;
    assign mst_aw_valid = rst_ni && (aw_hold_q || (slv_req_i.aw_valid && aw_ok));
    // An ATOP and an AR never claim the same read entry in one cycle.
    assign ar_conflict  = atop_rd && mst_aw_valid && (aw_sel_idx == ar_idx);
    assign ar_stall     = !ar_hold_q && (!ar_ok || ar_conflict);
    assign mst_ar_valid = rst_ni && (ar_hold_q || (slv_req_i.ar_valid && !ar_stall));

    assign aw_hs = mst_aw_valid && mst_resp_i.aw_ready;
    assign ar_hs = mst_ar_valid && mst_resp_i.ar_ready;
    assign b_hs  = rst_ni && mst_resp_i.b_valid && slv_req_i.b_ready;
    assign r_hs  = rst_ni && mst_resp_i.r_valid && slv_req_i.r_ready;

    // A response to an empty entry is forwarded but must not underflow.
    always_comb begin
        for (int i = 0; i < NumIds; i++) begin
            w_inc[i]    = aw_hs && aw_sel_idx == mid_t'(i);
            w_dec[i]    = b_hs && mst_resp_i.b.id == mid_t'(i) && w_cnt[i] != '0;
            r_inc_ar[i] = ar_hs && ar_sel_idx == mid_t'(i);
            r_inc_aw[i] = atop_rd && aw_hs && aw_sel_idx == mid_t'(i);
            r_dec[i]    = r_hs && mst_resp_i.r.last &&
                          mst_resp_i.r.id == mid_t'(i) && r_cnt[i] != '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_hold_q   <= 1'b0;
            aw_hold_idx <= '0;
            ar_hold_q   <= 1'b0;
            ar_hold_idx <= '0;
        end else begin
            aw_hold_q   <= mst_aw_valid && !mst_resp_i.aw_ready;
            aw_hold_idx <= aw_sel_idx;
            ar_hold_q   <= mst_ar_valid && !mst_resp_i.ar_ready;
            ar_hold_idx <= ar_sel_idx;
        end
    end

    // Alloc and free on the same entry cancel out; in_id is left alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumIds; i++) begin
                w_in_id[i] <= '0;
                w_cnt[i]   <= '0;
                r_in_id[i] <= '0;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NumIds; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    w_cnt[i]   <= w_cnt[i] + cnt_t'(1);
                    w_in_id[i] <= slv_req_i.aw.id;
                end else if (!w_inc[i] && w_dec[i]) begin
                    w_cnt[i]   <= w_cnt[i] - cnt_t'(1);
                end
                if ((r_inc_ar[i] || r_inc_aw[i]) && !r_dec[i]) begin
                    r_cnt[i]   <= r_cnt[i] + cnt_t'(1);
                    r_in_id[i] <= r_inc_ar[i] ? slv_req_i.ar.id : slv_req_i.aw.id;
                end else if (!(r_inc_ar[i] || r_inc_aw[i]) && r_dec[i]) begin
                    r_cnt[i]   <= r_cnt[i] - cnt_t'(1);
                end
            end
        end
    end

    always_comb begin
        mst_req_o           = '0;
        mst_req_o.aw.id     = aw_sel_idx;
        mst_req_o.aw.addr   = slv_req_i.aw.addr;
        mst_req_o.aw.len    = slv_req_i.aw.len;
        mst_req_o.aw.size   = slv_req_i.aw.size;
        mst_req_o.aw.burst  = slv_req_i.aw.burst;
        mst_req_o.aw.lock   = slv_req_i.aw.lock;
        mst_req_o.aw.cache  = slv_req_i.aw.cache;
        mst_req_o.aw.prot   = slv_req_i.aw.prot;
        mst_req_o.aw.qos    = slv_req_i.aw.qos;
        mst_req_o.aw.region = slv_req_i.aw.region;
`ifdef ARIANE_AXI_ID_REMAP_ATOP_EN
        mst_req_o.aw.atop   = slv_req_i.aw.atop;
`else
        mst_req_o.aw.atop   = '0;
`endif
        mst_req_o.aw.user   = slv_req_i.aw.user;
        mst_req_o.aw_valid  = mst_aw_valid;
        mst_req_o.w         = slv_req_i.w;
        mst_req_o.w_valid   = rst_ni && slv_req_i.w_valid;
        mst_req_o.b_ready   = rst_ni && slv_req_i.b_ready;
        mst_req_o.ar.id     = ar_sel_idx;
        mst_req_o.ar.addr   = slv_req_i.ar.addr;
        mst_req_o.ar.len    = slv_req_i.ar.len;
        mst_req_o.ar.size   = slv_req_i.ar.size;
        mst_req_o.ar.burst  = slv_req_i.ar.burst;
        mst_req_o.ar.lock   = slv_req_i.ar.lock;
        mst_req_o.ar.cache  = slv_req_i.ar.cache;
        mst_req_o.ar.prot   = slv_req_i.ar.prot;
        mst_req_o.ar.qos    = slv_req_i.ar.qos;
        mst_req_o.ar.region = slv_req_i.ar.region;
        mst_req_o.ar.user   = slv_req_i.ar.user;
        mst_req_o.ar_valid  = mst_ar_valid;
        mst_req_o.r_ready   = rst_ni && slv_req_i.r_ready;

        slv_resp_o          = '0;
        slv_resp_o.aw_ready = rst_ni && !aw_stall && mst_resp_i.aw_ready;
        slv_resp_o.ar_ready = rst_ni && !ar_stall && mst_resp_i.ar_ready;
        slv_resp_o.w_ready  = rst_ni && mst_resp_i.w_ready;
        slv_resp_o.b_valid  = rst_ni && mst_resp_i.b_valid;
        slv_resp_o.b.id     = w_in_id[mst_resp_i.b.id];
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b.user   = mst_resp_i.b.user;
        slv_resp_o.r_valid  = rst_ni && mst_resp_i.r_valid;
        slv_resp_o.r.id     = r_in_id[mst_resp_i.r.id];
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r.user   = mst_resp_i.r.user;
    end
endmodule
